// File: rtl/decim_filter_axil_regs_if.sv
// decim_filter_axil_regs_if: AXI4-Lite channel bundle between the VIP master and the
// decimation filter register file.
interface decim_filter_axil_regs_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic [2:0]              awprot;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic [2:0]              arprot;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/decim_filter_axil_regs.sv
// decim_filter_axil_regs: AXI4-Lite register file feeding config words to the filter core.
// Define DECIM_AXIL_SLVERR_EN to answer out-of-range accesses with SLVERR instead of aliasing.
module decim_filter_axil_regs #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_REGS   = 4
) (
  input  logic                           s00_axi_aclk,
  input  logic                           s00_axi_areset,
  decim_filter_axil_regs_if.slave        s00_axi,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS-1:0]            reg_wr_pulse
);
  localparam int IDX_W  = ADDR_WIDTH - 2;
  localparam int SEL_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef DECIM_AXIL_SLVERR_EN
  localparam bit SLVERR_EN = 1'b1;
`else
  localparam bit SLVERR_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   pulse_q, pulse_d;
  logic                  awHeld_q, wHeld_q;
  logic [ADDR_WIDTH-1:0] awAddr_q;
  logic [DATA_WIDTH-1:0] wData_q;
  logic [STRB_W-1:0]     wStrb_q;
  logic                  bvalid_q, rvalid_q;
  logic [1:0]            bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  awFire, wFire, arFire, commit, wrDrop, rdDrop;
  logic [ADDR_WIDTH-1:0] awAddrEff;
  logic [DATA_WIDTH-1:0] wDataEff;
  logic [STRB_W-1:0]     wStrbEff;
  logic [IDX_W-1:0]      wrIdx, rdIdx;
  logic                  unused;

  function automatic logic [SEL_W-1:0] regSel(input logic [IDX_W-1:0] idx);
    return SEL_W'(32'(idx) % NUM_REGS);
  endfunction

  assign s00_axi.awready = !awHeld_q && !bvalid_q && !s00_axi_areset;
  assign s00_axi.wready  = !wHeld_q && !bvalid_q && !s00_axi_areset;
  assign s00_axi.arready = !rvalid_q && !s00_axi_areset;
  assign s00_axi.bvalid  = bvalid_q;
  assign s00_axi.bresp   = bresp_q;
  assign s00_axi.rvalid  = rvalid_q;
  assign s00_axi.rresp   = rresp_q;
  assign s00_axi.rdata   = rdata_q;
  assign reg_wr_pulse    = pulse_q;

  assign awFire = s00_axi.awvalid && s00_axi.awready;
  assign wFire  = s00_axi.wvalid && s00_axi.wready;
  assign arFire = s00_axi.arvalid && s00_axi.arready;

  // A held beat takes priority; otherwise the beat handshaking this cycle is used directly.
  assign awAddrEff = awHeld_q ? awAddr_q : s00_axi.awaddr;
  assign wDataEff  = wHeld_q ? wData_q : s00_axi.wdata;
  assign wStrbEff  = wHeld_q ? wStrb_q : s00_axi.wstrb;
  assign commit    = (awHeld_q || awFire) && (wHeld_q || wFire);
  assign wrIdx     = awAddrEff[ADDR_WIDTH-1:2];
  assign rdIdx     = s00_axi.araddr[ADDR_WIDTH-1:2];
  assign wrDrop    = SLVERR_EN && (32'(wrIdx) >= NUM_REGS);
  assign rdDrop    = SLVERR_EN && (32'(rdIdx) >= NUM_REGS);

  assign unused = ^{s00_axi.awprot, s00_axi.arprot, awAddrEff[1:0], s00_axi.araddr[1:0]};

  always_comb begin
    regs_d  = regs_q;
    pulse_d = '0;
    bresp_d = RESP_OKAY;
    if (commit) begin
      if (wrDrop) begin
        bresp_d = RESP_SLVERR;
      end else begin
        pulse_d[regSel(wrIdx)] = 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wStrbEff[b]) regs_d[regSel(wrIdx)][8*b +: 8] = wDataEff[8*b +: 8];
        end
      end
    end
  end

  // Reads sample regs_q, so a same-cycle write commit is not yet visible.
  always_comb begin
    rdata_d = regs_q[regSel(rdIdx)];
    rresp_d = RESP_OKAY;
    if (rdDrop) begin
      rdata_d = '0;
      rresp_d = RESP_SLVERR;
    end
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      pulse_q  <= '0;
      awHeld_q <= 1'b0;
      wHeld_q  <= 1'b0;
      awAddr_q <= '0;
      wData_q  <= '0;
      wStrb_q  <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
      rvalid_q <= 1'b0;
      rresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
    end else begin
      regs_q  <= regs_d;
      pulse_q <= pulse_d;
      if (bvalid_q && s00_axi.bready) bvalid_q <= 1'b0;
      if (commit) begin
        awHeld_q <= 1'b0;
        wHeld_q  <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= bresp_d;
      end else begin
        if (awFire) begin
          awHeld_q <= 1'b1;
          awAddr_q <= s00_axi.awaddr;
        end
        if (wFire) begin
          wHeld_q <= 1'b1;
          wData_q <= s00_axi.wdata;
          wStrb_q <= s00_axi.wstrb;
        end
      end
      if (arFire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rdata_d;
        rresp_q  <= rresp_d;
      end else if (rvalid_q && s00_axi.rready) begin
        rvalid_q <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : gRegOut
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
  end
endmodule

// File: tb/tb_decim_filter_axil_regs.sv
// tb_decim_filter_axil_regs: table-driven + scoreboard bench for the AXI4-Lite register file.
// Honours DECIM_AXIL_SLVERR_EN the same way the design does.
module tb_decim_filter_axil_regs;
  localparam int TIMEOUT = 50;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] regOut;
  logic [3:0]   wrPulse;
  int           checks = 0;
  int           failures = 0;

  logic [31:0]  model [4];
  logic [1:0]   bQ [$];
  logic [33:0]  rQ [$];

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] expRd;
  } vec_t;
  vec_t vecs [7];

  decim_filter_axil_regs_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) axi ();

  decim_filter_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_REGS(4)) dut (
    .s00_axi_aclk  (clk),
    .s00_axi_areset(rst),
    .s00_axi       (axi),
    .reg_out       (regOut),
    .reg_wr_pulse  (wrPulse)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] modelPacked();
    return {model[3], model[2], model[1], model[0]};
  endfunction

  function automatic void modelWrite(input logic [4:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb, output logic [1:0] resp,
                                     output logic [3:0] pulse);
    int idx = int'(addr[4:2]);
    pulse = '0;
    resp  = 2'b00;
`ifdef DECIM_AXIL_SLVERR_EN
    if (idx >= 4) begin
      resp = 2'b10;
      return;
    end
`endif
    idx = idx % 4;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    end
    pulse[idx] = 1'b1;
  endfunction

  function automatic logic [33:0] modelRead(input logic [4:0] addr);
    int idx = int'(addr[4:2]);
`ifdef DECIM_AXIL_SLVERR_EN
    if (idx >= 4) return {2'b10, 32'h0};
`endif
    return {2'b00, model[idx % 4]};
  endfunction

  task automatic popBresp(input string name);
    logic [1:0] exp;
    exp = (bQ.size() != 0) ? bQ.pop_front() : 2'bxx;
    checkOutput({name, " bvalid"}, 128'(axi.bvalid), 128'(1'b1));
    checkOutput({name, " bresp"}, 128'(axi.bresp), 128'(exp));
  endtask

  task automatic axiWrite(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [1:0] resp;
    logic [3:0] pulse;
    int n = 0;
    modelWrite(addr, data, strb, resp, pulse);
    bQ.push_back(resp);
    axi.awaddr = addr; axi.awvalid = 1'b1;
    axi.wdata = data; axi.wstrb = strb; axi.wvalid = 1'b1;
    while (!(axi.awready && axi.wready) && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wr ready", 128'({axi.awready, axi.wready}), 128'(2'b11));
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0;
    checkOutput("wr pulse", 128'(wrPulse), 128'(pulse));
    popBresp("wr");
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    checkOutput("wr pulse clear", 128'(wrPulse), 128'(0));
  endtask

  task automatic axiRead(input logic [4:0] addr, output logic [31:0] data);
    logic [33:0] exp;
    int n = 0;
    rQ.push_back(modelRead(addr));
    axi.araddr = addr; axi.arvalid = 1'b1;
    while (!axi.arready && n < TIMEOUT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rd arready", 128'(axi.arready), 128'(1'b1));
    @(negedge clk);
    axi.arvalid = 1'b0;
    checkOutput("rd rvalid", 128'(axi.rvalid), 128'(1'b1));
    exp = (rQ.size() != 0) ? rQ.pop_front() : 34'bx;
    checkOutput("rd rdata", 128'(axi.rdata), 128'(exp[31:0]));
    checkOutput("rd rresp", 128'(axi.rresp), 128'(exp[33:32]));
    data = axi.rdata;
    axi.rready = 1'b1;
    @(negedge clk);
    axi.rready = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] rd;
    axiWrite(v.addr, v.data, v.strb);
    axiRead(v.addr, rd);
    checkOutput("table readback", 128'(rd), 128'(v.expRd));
    checkOutput("table reg_out", regOut, modelPacked());
  endtask

  initial begin
    logic [31:0] rd;
    logic [1:0]  resp, resp2;
    logic [3:0]  pulse, pulse2;

    vecs[0] = '{5'h00, 32'h0000_0001, 4'hF, 32'h0000_0001};
    vecs[1] = '{5'h04, 32'h0000_0002, 4'hF, 32'h0000_0002};
    vecs[2] = '{5'h08, 32'h0000_0003, 4'hF, 32'h0000_0003};
    vecs[3] = '{5'h0C, 32'h0000_0004, 4'hF, 32'h0000_0004};
    vecs[4] = '{5'h00, 32'hAABB_CCDD, 4'b0010, 32'h0000_CC01};
    vecs[5] = '{5'h04, 32'h1122_3344, 4'b1001, 32'h1100_0044};
    vecs[6] = '{5'h0A, 32'hFFFF_FFFF, 4'b0100, 32'h00FF_0003};

    for (int i = 0; i < 4; i++) model[i] = '0;
    axi.awaddr = '0; axi.awprot = '0; axi.awvalid = 1'b0;
    axi.wdata = '0; axi.wstrb = '0; axi.wvalid = 1'b0; axi.bready = 1'b0;
    axi.araddr = '0; axi.arprot = '0; axi.arvalid = 1'b0; axi.rready = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("reset readies", 128'({axi.awready, axi.wready, axi.arready}), 128'(3'b000));
    checkOutput("reset valids", 128'({axi.bvalid, axi.rvalid}), 128'(2'b00));
    checkOutput("reset resp", 128'({axi.bresp, axi.rresp, axi.rdata}), 128'(0));
    checkOutput("reset reg_out", regOut, 128'(0));
    checkOutput("reset pulse", 128'(wrPulse), 128'(0));
    rst = 1'b0;
    #1;
    checkOutput("post-reset readies", 128'({axi.awready, axi.wready, axi.arready}), 128'(3'b111));
    @(negedge clk);

    $display("[TB] table vectors");
    for (int i = 0; i < 7; i++) applyStimulus(vecs[i]);
    for (int i = 0; i < 4; i++) axiRead(5'(i * 4), rd);

    $display("[TB] W leads AW by three cycles");
    modelWrite(5'h0C, 32'h1234_5678, 4'hF, resp, pulse);
    bQ.push_back(resp);
    axi.wdata = 32'h1234_5678; axi.wstrb = 4'hF; axi.wvalid = 1'b1;
    checkOutput("early wready", 128'(axi.wready), 128'(1'b1));
    @(negedge clk);
    axi.wvalid = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      checkOutput("wready held low", 128'(axi.wready), 128'(1'b0));
      checkOutput("bvalid not early", 128'(axi.bvalid), 128'(1'b0));
      if (c == 3) begin
        axi.awaddr = 5'h0C;
        axi.awvalid = 1'b1;
      end
      @(negedge clk);
    end
    axi.awvalid = 1'b0;
    checkOutput("late commit pulse", 128'(wrPulse), 128'(pulse));
    checkOutput("late commit reg_out", regOut, modelPacked());
    popBresp("late commit");
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    checkOutput("late pulse one cycle", 128'(wrPulse), 128'(0));
    checkOutput("late bvalid drop", 128'(axi.bvalid), 128'(1'b0));

    $display("[TB] B backpressure stalls AW");
    modelWrite(5'h08, 32'hCAFE_F00D, 4'hF, resp, pulse);
    bQ.push_back(resp);
    axi.awaddr = 5'h08; axi.awvalid = 1'b1;
    axi.wdata = 32'hCAFE_F00D; axi.wvalid = 1'b1; axi.wstrb = 4'hF;
    @(negedge clk);
    axi.wvalid = 1'b0;
    axi.awaddr = 5'h04;
    checkOutput("bp pulse", 128'(wrPulse), 128'(pulse));
    for (int c = 0; c < 5; c++) begin
      checkOutput("bp bvalid stable", 128'(axi.bvalid), 128'(1'b1));
      checkOutput("bp bresp stable", 128'(axi.bresp), 128'(resp));
      checkOutput("bp awready stalled", 128'(axi.awready), 128'(1'b0));
      @(negedge clk);
    end
    popBresp("bp");
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    modelWrite(5'h04, 32'h0BAD_BEEF, 4'hF, resp2, pulse2);
    bQ.push_back(resp2);
    checkOutput("bp awready resumes", 128'(axi.awready), 128'(1'b1));
    @(negedge clk);
    axi.awvalid = 1'b0;
    axi.wdata = 32'h0BAD_BEEF; axi.wvalid = 1'b1;
    checkOutput("bp second wready", 128'(axi.wready), 128'(1'b1));
    @(negedge clk);
    axi.wvalid = 1'b0;
    checkOutput("bp second pulse", 128'(wrPulse), 128'(pulse2));
    popBresp("bp second");
    axi.bready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0;
    checkOutput("bp reg_out", regOut, modelPacked());

    $display("[TB] read and write same register together");
    rQ.push_back(modelRead(5'h0C));
    modelWrite(5'h0C, 32'h8765_4321, 4'hF, resp, pulse);
    bQ.push_back(resp);
    axi.awaddr = 5'h0C; axi.awvalid = 1'b1;
    axi.wdata = 32'h8765_4321; axi.wvalid = 1'b1;
    axi.araddr = 5'h0C; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.arvalid = 1'b0;
    begin
      logic [33:0] exp;
      exp = (rQ.size() != 0) ? rQ.pop_front() : 34'bx;
      checkOutput("rw rvalid", 128'(axi.rvalid), 128'(1'b1));
      checkOutput("rw old rdata", 128'(axi.rdata), 128'(exp[31:0]));
    end
    popBresp("rw");
    checkOutput("rw reg_out new", regOut, modelPacked());
    axi.bready = 1'b1; axi.rready = 1'b1;
    @(negedge clk);
    axi.bready = 1'b0; axi.rready = 1'b0;

    $display("[TB] out-of-range address 0x10");
    axiWrite(5'h10, 32'hDEAD_BEEF, 4'hF);
    checkOutput("oor reg_out", regOut, modelPacked());
    axiRead(5'h10, rd);

    $display("[TB] reset while rvalid is high");
    axiWrite(5'h04, 32'h0000_0055, 4'hF);
    axi.araddr = 5'h04; axi.arvalid = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    checkOutput("pre-reset rvalid", 128'(axi.rvalid), 128'(1'b1));
    checkOutput("pre-reset rdata", 128'(axi.rdata), 128'(32'h55));
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid-reset rvalid", 128'(axi.rvalid), 128'(1'b0));
    checkOutput("mid-reset reg_out", regOut, 128'(0));
    checkOutput("mid-reset arready", 128'(axi.arready), 128'(1'b0));
    for (int i = 0; i < 4; i++) model[i] = '0;
    rQ.delete();
    bQ.delete();
    rst = 1'b0;
    #1;
    checkOutput("post-reset arready", 128'(axi.arready), 128'(1'b1));
    @(negedge clk);
    axiRead(5'h04, rd);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
